// File: rtl/serial_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_pkg                                                   |
// | Description : Shared types and constants for the serial transceiver:      |
// |               TX/RX state encodings, line-level constants and a helper    |
// |               returning the number of bit slots in one frame.             |
// | Options     : SERIAL_TRANSCEIVER_PARITY_EN adds the even-parity bit slot.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package serial_pkg;

   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      TX_IDLE    = 3'd0,
      TX_PENDING = 3'd1,
      TX_START   = 3'd2,
      TX_DATA    = 3'd3,
      TX_STOP    = 3'd4
`ifdef SERIAL_TRANSCEIVER_PARITY_EN
      , TX_PARITY = 3'd5
`endif
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_HIGH = 3'd4
`ifdef SERIAL_TRANSCEIVER_PARITY_EN
      , RX_PARITY = 3'd5
`endif
   } rx_state_t;

   // Bit slots per frame: start + data + [parity] + stop.
   function automatic int frame_bits(input int data_width);
`ifdef SERIAL_TRANSCEIVER_PARITY_EN
      return data_width + 3;
`else
      return data_width + 2;
`endif
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_bit_timer                                             |
// | Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; tick  |
// |               is high in the last cycle of each bit period.               |
// | Ports       : clock, reset     - clock / synchronous active-high reset     |
// |               restart          - force count to 0 on the next edge         |
// |               preload_half     - load CLKS_PER_BIT/2 so the next tick      |
// |                                  lands half a bit later (mid-bit)          |
// |               tick             - last cycle of the current bit period      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module serial_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   input  logic preload_half,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_COUNT = CW'(CLKS_PER_BIT / 2);

   logic [CW-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || restart) begin
         count <= '0;
      end else if (preload_half) begin
         count <= HALF_COUNT;
      end else if (count == LAST_COUNT) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/serial_transceiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_transceiver                                           |
// | Description : Full-duplex asynchronous serial link. Independent TX (load / |
// |               transmitEnable / charSent handshake) and RX (2-flop sync,    |
// |               half-bit start qualification, mid-bit sampling, framing     |
// |               error). Frames are LSB first, idle high.                    |
// | Options     : `define SERIAL_TRANSCEIVER_PARITY_EN for an even-parity bit. |
// | Ports       : clock, reset      - clock / synchronous active-high reset    |
// |               txData, load      - word to send, capture strobe             |
// |               transmitEnable    - lets a captured word start               |
// |               charSent, txBusy  - end-of-stop pulse, TX occupied           |
// |               serialOut         - TX line                                  |
// |               serialIn          - RX line (asynchronous)                   |
// |               parallelOut       - last good received word                  |
// |               charReceived      - pulse with each parallelOut update       |
// |               framingError      - pulse on a low stop bit                  |
// |               parityError       - pulse on parity mismatch                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module serial_transceiver
   import serial_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] txData,
   input  logic                  load,
   input  logic                  transmitEnable,
   output logic                  charSent,
   output logic                  txBusy,
   output logic                  serialOut,
   input  logic                  serialIn,
   output logic [DATA_WIDTH-1:0] parallelOut,
   output logic                  charReceived,
   output logic                  framingError,
   output logic                  parityError
);

   localparam int IW = $clog2(DATA_WIDTH + 1);
   localparam logic [IW-1:0] LAST_INDEX = IW'(DATA_WIDTH - 1);

   // ------------------------------------------------------------------ TX --
   tx_state_t             tx_state;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] tx_shifted;
   logic [IW-1:0]         tx_index;
   logic                  tx_tick;
   logic                  tx_restart;
`ifdef SERIAL_TRANSCEIVER_PARITY_EN
   logic                  tx_parity;
`endif

   // Holding the timer at zero until START makes the start bit exactly one
   // bit period long, measured from the first low cycle.
   assign tx_restart = (tx_state == TX_IDLE) || (tx_state == TX_PENDING);
   assign tx_shifted = tx_shift >> 1;

   serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
      .clock        (clock),
      .reset        (reset),
      .restart      (tx_restart),
      .preload_half (1'b0),
      .tick         (tx_tick)
   );

   // serialOut is registered so the line never glitches on state decode.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state  <= TX_IDLE;
         serialOut <= IDLE_LEVEL;
         tx_shift  <= '0;
         tx_index  <= '0;
`ifdef SERIAL_TRANSCEIVER_PARITY_EN
         tx_parity <= 1'b0;
`endif
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (load) begin
                  tx_shift  <= txData;
`ifdef SERIAL_TRANSCEIVER_PARITY_EN
                  tx_parity <= ^txData;
`endif
                  tx_state  <= TX_PENDING;
               end
            end
            TX_PENDING: begin
               if (transmitEnable) begin
                  tx_state  <= TX_START;
                  serialOut <= 1'b0;
               end
            end
            TX_START: begin
               if (tx_tick) begin
                  tx_state  <= TX_DATA;
                  serialOut <= tx_shift[0];
                  tx_index  <= '0;
               end
            end
            TX_DATA: begin
               if (tx_tick) begin
                  if (tx_index == LAST_INDEX) begin
`ifdef SERIAL_TRANSCEIVER_PARITY_EN
                     tx_state  <= TX_PARITY;
                     serialOut <= tx_parity;
`else
                     tx_state  <= TX_STOP;
                     serialOut <= STOP_BIT;
`endif
                  end else begin
                     tx_shift  <= tx_shifted;
                     serialOut <= tx_shifted[0];
                     tx_index  <= tx_index + 1'b1;
                  end
               end
            end
`ifdef SERIAL_TRANSCEIVER_PARITY_EN
            TX_PARITY: begin
               if (tx_tick) begin
                  tx_state  <= TX_STOP;
                  serialOut <= STOP_BIT;
               end
            end
`endif
            TX_STOP: begin
               if (tx_tick) begin
                  tx_state  <= TX_IDLE;
                  serialOut <= IDLE_LEVEL;
               end
            end
            default: begin
               tx_state  <= TX_IDLE;
               serialOut <= IDLE_LEVEL;
            end
         endcase
      end
   end

   assign charSent = (tx_state == TX_STOP) && tx_tick;
   assign txBusy   = (tx_state != TX_IDLE);

   // ------------------------------------------------------------------ RX --
   logic                  rx_meta;
   logic                  rx_bit;
   rx_state_t             rx_state;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic [DATA_WIDTH:0]   rx_cat;
   logic [IW-1:0]         rx_index;
   logic                  rx_tick;
   logic                  rx_detect;
   logic                  rx_parity_ok;
`ifdef SERIAL_TRANSCEIVER_PARITY_EN
   logic                  rx_parity_bad;
   logic                  parity_pulse;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta <= IDLE_LEVEL;
         rx_bit  <= IDLE_LEVEL;
      end else begin
         rx_meta <= serialIn;
         rx_bit  <= rx_meta;
      end
   end

   // Preloading half a period on the first low cycle puts every later tick
   // in the middle of a bit, starting with the start bit itself.
   assign rx_detect = (rx_state == RX_IDLE) && (rx_bit == 1'b0);
   assign rx_cat    = {rx_bit, rx_shift};

   serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
      .clock        (clock),
      .reset        (reset),
      .restart      (1'b0),
      .preload_half (rx_detect),
      .tick         (rx_tick)
   );

`ifdef SERIAL_TRANSCEIVER_PARITY_EN
   assign rx_parity_ok = !rx_parity_bad;
   assign parityError  = parity_pulse;
`else
   assign rx_parity_ok = 1'b1;
   assign parityError  = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_state      <= RX_IDLE;
         rx_shift      <= '0;
         rx_index      <= '0;
         parallelOut   <= '0;
         charReceived  <= 1'b0;
         framingError  <= 1'b0;
`ifdef SERIAL_TRANSCEIVER_PARITY_EN
         rx_parity_bad <= 1'b0;
         parity_pulse  <= 1'b0;
`endif
      end else begin
         charReceived <= 1'b0;
         framingError <= 1'b0;
`ifdef SERIAL_TRANSCEIVER_PARITY_EN
         parity_pulse <= 1'b0;
`endif
         case (rx_state)
            RX_IDLE: begin
               if (rx_detect) begin
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_tick) begin
                  if (rx_bit) begin
                     rx_state <= RX_IDLE;   // glitch shorter than half a bit
                  end else begin
                     rx_state <= RX_DATA;
                     rx_index <= '0;
                  end
               end
            end
            RX_DATA: begin
               if (rx_tick) begin
                  rx_shift <= rx_cat[DATA_WIDTH:1];
                  if (rx_index == LAST_INDEX) begin
`ifdef SERIAL_TRANSCEIVER_PARITY_EN
                     rx_state <= RX_PARITY;
`else
                     rx_state <= RX_STOP;
`endif
                  end else begin
                     rx_index <= rx_index + 1'b1;
                  end
               end
            end
`ifdef SERIAL_TRANSCEIVER_PARITY_EN
            RX_PARITY: begin
               if (rx_tick) begin
                  // Even parity: data bits plus parity bit must XOR to 0.
                  rx_parity_bad <= rx_bit ^ (^rx_shift);
                  rx_state      <= RX_STOP;
               end
            end
`endif
            RX_STOP: begin
               if (rx_tick) begin
`ifdef SERIAL_TRANSCEIVER_PARITY_EN
                  parity_pulse <= rx_parity_bad;
`endif
                  if (rx_bit == STOP_BIT) begin
                     rx_state <= RX_IDLE;
                     if (rx_parity_ok) begin
                        parallelOut  <= rx_shift;
                        charReceived <= 1'b1;
                     end
                  end else begin
                     framingError <= 1'b1;
                     rx_state     <= RX_WAIT_HIGH;
                  end
               end
            end
            RX_WAIT_HIGH: begin
               if (rx_bit == IDLE_LEVEL) begin
                  rx_state <= RX_IDLE;
               end
            end
            default: begin
               rx_state <= RX_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
